// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for OTTER memory data port 2: programmer (R0) vs CPU (R1).
// Combinational grant with programmer lock mode, CPU anti-starvation and registered read-return routing.
module mem_port_arbiter #(
    parameter int MAX_CONSEC = 8,
    parameter int CNT_W      = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,

    input  logic        R0_REQ,
    input  logic        R0_LOCK,
    input  logic        R0_WE,
    input  logic [31:0] R0_ADDR,
    input  logic [31:0] R0_WDATA,
    output logic        R0_GNT,
    output logic        R0_RVALID,

    input  logic        R1_REQ,
    input  logic        R1_WE,
    input  logic [31:0] R1_ADDR,
    input  logic [31:0] R1_WDATA,
    input  logic [1:0]  R1_SIZE,
    input  logic        R1_SIGN,
    output logic        R1_GNT,
    output logic        R1_RVALID,

    output logic [31:0] RDATA,

    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,

    output logic        LOCKED
);

    typedef enum logic {
        ARB   = 1'b0,
        LOCK0 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CONSEC);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_r0_rvalid;
    logic             r_r1_rvalid;

    logic             w_hold_lock;
    logic             w_arb_r0;
    logic             w_arb_r1;
    logic             w_r0_gnt;
    logic             w_r1_gnt;

    // R1 wins a contested cycle only once R0 has used up its consecutive-grant allowance.
    assign w_arb_r0    = R0_REQ & (~R1_REQ | (r_cnt != MAX_CNT));
    assign w_arb_r1    = R1_REQ & ~w_arb_r0;

    // The cycle in which LOCK drops is arbitrated normally, so only a held LOCK shuts R1 out.
    assign w_hold_lock = (r_state == LOCK0) & R0_LOCK;
    assign w_r0_gnt    = w_hold_lock ? R0_REQ : w_arb_r0;
    assign w_r1_gnt    = ~w_hold_lock & w_arb_r1;

    assign R0_GNT      = w_r0_gnt;
    assign R1_GNT      = w_r1_gnt;
    assign LOCKED      = (r_state == LOCK0);

    // NOTE: every output of a combinational block is given a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB:     if (R0_LOCK && R0_REQ && w_r0_gnt) w_next_state = LOCK0;
            LOCK0:   if (!R0_LOCK)                      w_next_state = ARB;
            default: w_next_state = ARB;
        endcase
    end

    always_comb begin
        MEM_ADDR2  = '0;
        MEM_DIN2   = '0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        MEM_SIZE   = 2'b00;
        MEM_SIGN   = 1'b0;
        if (w_r0_gnt) begin
            MEM_ADDR2  = R0_ADDR;
            MEM_DIN2   = R0_WDATA;
            MEM_WRITE2 = R0_WE;
            MEM_READ2  = ~R0_WE;
            MEM_SIZE   = 2'b10;
        end else if (w_r1_gnt) begin
            MEM_ADDR2  = R1_ADDR;
            MEM_DIN2   = R1_WDATA;
            MEM_WRITE2 = R1_WE;
            MEM_READ2  = ~R1_WE;
            MEM_SIZE   = R1_SIZE;
            MEM_SIGN   = R1_SIGN;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ARB;
            r_cnt       <= '0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_r0_rvalid <= w_r0_gnt & ~R0_WE;
            r_r1_rvalid <= w_r1_gnt & ~R1_WE;
            if (w_r1_gnt || !R1_REQ) begin
                r_cnt <= '0;
            end else if (w_r0_gnt && r_cnt != MAX_CNT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Memory read data arrives one cycle after the grant, aligned with the registered owner tag.
    assign R0_RVALID = r_r0_rvalid;
    assign R1_RVALID = r_r1_rvalid;
    assign RDATA     = MEM_DOUT2;

endmodule
